// File: rtl/divisor_secuencial_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divisor_secuencial_pkg;

  localparam int unsigned DefaultW = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  // Quotient reported on divide-by-zero or quotient overflow.
  localparam logic [DefaultW-1:0] ErrQuot = {DefaultW{1'b1}};

endpackage

// File: rtl/divisor_secuencial_div_paso.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module divisor_secuencial_div_paso #(
  parameter int unsigned W = 32
) (
  input  logic [W:0]   r_i,
  input  logic [W-1:0] q_i,
  input  logic [W-1:0] divisor_i,
  output logic [W:0]   r_o,
  output logic [W-1:0] q_o,
  output logic         qbit_o
);

  logic [W:0] t;
  logic [W:0] diff;
  logic       unused_r;

  // R < divisor at every step, so R[W] is always zero and drops out of T.
  assign unused_r = r_i[W];

  always_comb begin
    t      = {r_i[W-1:0], q_i[W-1]};
    diff   = t - {1'b0, divisor_i};
    qbit_o = (t >= {1'b0, divisor_i});
    r_o    = qbit_o ? diff : t;
    q_o    = {q_i[W-2:0], qbit_o};
  end

endmodule

// File: rtl/divisor_secuencial.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Optional macro DIV_FAST_PATH_EN: divisor==1 and dividend==0 finish straight from IDLE.
module divisor_secuencial
  import divisor_secuencial_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  input  logic           valid_data,
  input  logic           ack,
  output logic [W-1:0]   quot,
  output logic [W-1:0]   rem,
  output logic           div_err,
  output logic           Done_Flag
);

  localparam int unsigned     CntW    = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);
  localparam logic [W-1:0]    ErrQ    = {W{ErrQuot[0]}};

  state_e          state_q, state_d;
  logic [W:0]      r_q, r_d, step_r;
  logic [W-1:0]    q_q, q_d, step_q;
  logic [W-1:0]    dvs_q, dvs_d;
  logic [W-1:0]    quot_q, quot_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            step_qbit;
  logic [W-1:0]    dvd_hi, dvd_lo;
  logic            ovf;
  logic            last;

  assign dvd_hi = dividend[2*W-1:W];
  assign dvd_lo = dividend[W-1:0];
  assign ovf    = (divisor == '0) || (dvd_hi >= divisor);
  assign last   = (cnt_q == CntLast);

`ifdef DIV_FAST_PATH_EN
  logic fast;
  assign fast = (divisor == W'(1)) || (dividend == '0);
`endif

  divisor_secuencial_div_paso #(
    .W(W)
  ) u_paso (
    .r_i      (r_q),
    .q_i      (q_q),
    .divisor_i(dvs_q),
    .r_o      (step_r),
    .q_o      (step_q),
    .qbit_o   (step_qbit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (valid_data) begin
          if (ovf) begin
            state_d = StDone;
`ifdef DIV_FAST_PATH_EN
          end else if (fast) begin
            state_d = StDone;
`endif
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: if (last) state_d = StDone;
      StDone: if (ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    Done_Flag = (state_q == StDone);
  end

  always_comb begin
    r_d    = r_q;
    q_d    = q_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    err_d  = err_q;
    unique case (state_q)
      StIdle: begin
        if (valid_data) begin
          dvs_d = divisor;
          r_d   = {1'b0, dvd_hi};
          q_d   = dvd_lo;
          cnt_d = '0;
          if (ovf) begin
            quot_d = ErrQ;
            rem_d  = '0;
            err_d  = 1'b1;
`ifdef DIV_FAST_PATH_EN
          end else if (fast) begin
            // Both trivial cases have quotient == low dividend half (zero when dividend==0).
            quot_d = dvd_lo;
            rem_d  = '0;
            err_d  = 1'b0;
`endif
          end
        end
      end
      StCalc: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + CntW'(1);
        if (last) begin
          quot_d = {q_q[W-2:0], step_qbit};
          rem_d  = step_r[W-1:0];
          err_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q    <= '0;
      q_q    <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      r_q    <= r_d;
      q_q    <= q_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      err_q  <= err_d;
    end
  end

  assign quot    = quot_q;
  assign rem     = rem_q;
  assign div_err = err_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Bench for divisor_secuencial: vector table plus scoreboard, and handshake/reset corner sequences.
module tb_divisor_secuencial;

  localparam int W       = 32;
  localparam int LatCalc = W + 1;
  localparam int MaxLat  = 200;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [63:0]   dividend = '0;
  logic [31:0]   divisor = '0;
  logic          valid_data = 1'b0;
  logic          ack = 1'b0;
  logic [31:0]   quot;
  logic [31:0]   rem;
  logic          div_err;
  logic          Done_Flag;

  divisor_secuencial #(
    .W(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dividend  (dividend),
    .divisor   (divisor),
    .valid_data(valid_data),
    .ack       (ack),
    .quot      (quot),
    .rem       (rem),
    .div_err   (div_err),
    .Done_Flag (Done_Flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        err;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  function automatic int exp_lat(input logic [63:0] dvd, input logic [31:0] dvs, input logic err);
    if (err) return 1;
`ifdef DIV_FAST_PATH_EN
    if (dvs == 32'd1 || dvd == 64'd0) return 1;
`endif
    return LatCalc;
  endfunction

  function automatic vec_t model(input logic [63:0] dvd, input logic [31:0] dvs);
    vec_t v;
    v.dvd = dvd;
    v.dvs = dvs;
    v.err = (dvs == 32'd0) || (dvd[63:32] >= dvs);
    if (v.err) begin
      v.q = 32'hFFFF_FFFF;
      v.r = 32'd0;
    end else begin
      v.q = 32'(dvd / {32'd0, dvs});
      v.r = 32'(dvd % {32'd0, dvs});
    end
    return v;
  endfunction

  // Drives one start cycle, pushes the expectation, then scrambles the operand inputs.
  task automatic launch(input vec_t v, input string name);
    exp_t e;
    e = '{v.q, v.r, v.err, exp_lat(v.dvd, v.dvs, v.err), name};
    sb.push_back(e);
    @(negedge clk);
    dividend   = v.dvd;
    divisor    = v.dvs;
    valid_data = 1'b1;
    @(negedge clk);
    valid_data = 1'b0;
    dividend   = {$urandom, $urandom};
    divisor    = $urandom;
  endtask

  task automatic collect(input int lat0, output exp_t e);
    int lat;
    lat = lat0;
    while (!Done_Flag && lat < MaxLat) begin
      @(negedge clk);
      lat++;
    end
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard: queue empty, required one pending result");
      e = '{32'd0, 32'd0, 1'b0, 0, "none"};
    end else begin
      e = sb.pop_front();
      chk({e.name, "_lat"}, 64'(lat), 64'(e.lat));
      chk({e.name, "_done"}, 64'(Done_Flag), 64'd1);
      chk({e.name, "_quot"}, 64'(quot), 64'(e.q));
      chk({e.name, "_rem"}, 64'(rem), 64'(e.r));
      chk({e.name, "_err"}, 64'(div_err), 64'(e.err));
    end
  endtask

  task automatic do_ack(input exp_t e);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk({e.name, "_ack_clr"}, 64'(Done_Flag), 64'd0);
    chk({e.name, "_quot_kept"}, 64'(quot), 64'(e.q));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[11];
    vec_t        v;
    exp_t        e;
    logic [31:0] hi;
    int          lat;

    tbl[0]  = '{64'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    tbl[1]  = '{64'h0000_0001_0000_0000, 32'd2, 32'h8000_0000, 32'd0, 1'b0};
    tbl[2]  = '{64'h0000_0000_0000_1234, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1};
    tbl[3]  = '{64'h0000_0005_0000_0000, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b1};
    tbl[4]  = '{64'hDEAD_BEEF * 64'h0001_2345 + 64'h0000_1000, 32'h0001_2345,
                32'hDEAD_BEEF, 32'h0000_1000, 1'b0};
    tbl[5]  = '{64'd77, 32'd1, 32'd77, 32'd0, 1'b0};
    tbl[6]  = '{64'd0, 32'd9, 32'd0, 32'd0, 1'b0};
    tbl[7]  = '{64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    tbl[8]  = '{64'd1, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0};
    tbl[9]  = '{64'h0000_0007_0000_0000, 32'd7, 32'hFFFF_FFFF, 32'd0, 1'b1};
    tbl[10] = '{64'h0000_0006_FFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'd6, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_done", 64'(Done_Flag), 64'd0);
    chk("rst_quot", 64'(quot), 64'd0);
    chk("rst_rem", 64'(rem), 64'd0);
    chk("rst_err", 64'(div_err), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      launch(tbl[i], $sformatf("v%0d", i));
      collect(1, e);
      repeat (2) @(negedge clk);
      chk({e.name, "_hold"}, 64'({Done_Flag, div_err, quot, rem}),
          64'({1'b1, e.err, e.q, e.r}));
      do_ack(e);
    end

    for (int k = 0; k < 4; k++) begin
      v.dvs = $urandom | 32'd1;
      hi    = $urandom % v.dvs;
      v     = model({hi, $urandom}, v.dvs);
      launch(v, $sformatf("rnd%0d", k));
      collect(1, e);
      do_ack(e);
    end

    // valid_data toggling in CALC must not restart; ack held early must not disturb CALC.
    launch(tbl[0], "tog");
    ack = 1'b1;
    lat = 1;
    for (int c = 0; c < 20; c++) begin
      valid_data = c[0];
      @(negedge clk);
      lat++;
    end
    valid_data = 1'b0;
    collect(lat, e);
    @(negedge clk);
    chk("tog_ack_held_clr", 64'(Done_Flag), 64'd0);
    ack = 1'b0;

    // Async reset mid-CALC discards the job and clears outputs at once.
    launch(tbl[1], "midrst");
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_outs", 64'({Done_Flag, div_err, quot, rem}), 64'd0);
    void'(sb.pop_front());
    @(negedge clk);
    reset = 1'b1;
    launch(tbl[0], "after_rst");
    collect(1, e);
    do_ack(e);

    // ack together with valid_data in DONE: ack wins, no new job starts.
    launch(tbl[2], "ackvalid");
    collect(1, e);
    ack        = 1'b1;
    valid_data = 1'b1;
    @(negedge clk);
    ack        = 1'b0;
    valid_data = 1'b0;
    chk("ackvalid_clr", 64'(Done_Flag), 64'd0);
    repeat (40) @(negedge clk);
    chk("ackvalid_no_restart", 64'(Done_Flag), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
